// File: rtl/net2_arbiter.sv
// ============================================================================
// Module   : net2_arbiter
// Purpose  : Two-requester round-robin arbiter feeding a single-entry output
//            register stage. Optional packet locking: NET2_ARBITER_PKT_LOCK_EN
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module net2_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN1_DATA,
  input  logic             IN1_VALID,
  input  logic             IN1_LAST,
  output logic             IN1_READY,
  input  logic [WIDTH-1:0] IN2_DATA,
  input  logic             IN2_VALID,
  input  logic             IN2_LAST,
  output logic             IN2_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  output logic             OUT_LAST,
  input  logic             OUT_READY,
  output logic             OUT_SRC
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic             out_src_q,   out_src_d;
  logic             pri_q,       pri_d;
`ifdef NET2_ARBITER_PKT_LOCK_EN
  logic             lock_q,      lock_d;
  logic             lock_src_q,  lock_src_d;
`endif

  logic             load_ok;
  logic             gnt_vld;
  logic             gnt_src;
  logic             accept;
  logic [WIDTH-1:0] acc_data;
  logic             acc_last;

  assign load_ok = ~out_valid_q | OUT_READY;

  // Grant depends only on VALIDs, the pointer and lock state, never on data.
  always_comb begin
    gnt_vld = IN1_VALID | IN2_VALID;
    gnt_src = 1'b0;
    if (IN1_VALID && IN2_VALID) begin
      gnt_src = pri_q;
    end else if (IN2_VALID) begin
      gnt_src = 1'b1;
    end
`ifdef NET2_ARBITER_PKT_LOCK_EN
    if (lock_q) begin
      gnt_src = lock_src_q;
      gnt_vld = lock_src_q ? IN2_VALID : IN1_VALID;
    end
`endif
  end

  assign accept    = RST_N & load_ok & gnt_vld;
  assign IN1_READY = accept & ~gnt_src;
  assign IN2_READY = accept &  gnt_src;
  assign acc_data  = gnt_src ? IN2_DATA : IN1_DATA;
  assign acc_last  = gnt_src ? IN2_LAST : IN1_LAST;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    pri_d       = pri_q;
`ifdef NET2_ARBITER_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_src_d  = lock_src_q;
`endif
    if (load_ok) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = acc_data;
        out_last_d = acc_last;
        out_src_d  = gnt_src;
      end
    end
    if (accept) begin
`ifdef NET2_ARBITER_PKT_LOCK_EN
      // Arbitration reopens only when the packet's final beat is taken.
      lock_d     = ~acc_last;
      lock_src_d = gnt_src;
      if (acc_last) begin
        pri_d = ~gnt_src;
      end
`else
      pri_d = ~gnt_src;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
      pri_q       <= 1'b0;
`ifdef NET2_ARBITER_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_src_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      pri_q       <= pri_d;
`ifdef NET2_ARBITER_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_src_q  <= lock_src_d;
`endif
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_SRC   = out_src_q;

endmodule

`default_nettype wire

// File: tb/tb_net2_arbiter.sv
// ============================================================================
// Module   : tb_net2_arbiter
// Purpose  : Self-checking bench for net2_arbiter: queue-based reference model
//            plus directed scenarios. Honours NET2_ARBITER_PKT_LOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_net2_arbiter;

  localparam int WIDTH = 32;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [WIDTH-1:0] IN1_DATA, IN2_DATA, OUT_DATA;
  logic             IN1_VALID, IN1_LAST, IN1_READY;
  logic             IN2_VALID, IN2_LAST, IN2_READY;
  logic             OUT_VALID, OUT_LAST, OUT_READY, OUT_SRC;

  int n_vec = 0;
  int n_err = 0;

  net2_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN1_DATA(IN1_DATA), .IN1_VALID(IN1_VALID), .IN1_LAST(IN1_LAST), .IN1_READY(IN1_READY),
    .IN2_DATA(IN2_DATA), .IN2_VALID(IN2_VALID), .IN2_LAST(IN2_LAST), .IN2_READY(IN2_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY),
    .OUT_SRC(OUT_SRC)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the output register is a queue of accepted beats.
  typedef struct packed {
    logic             src;
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t mq[$];
  logic  m_pri  = 1'b0;
  logic  m_lock = 1'b0;
  logic  m_lsrc = 1'b0;

  always @(negedge CLK) begin
    logic  ld, gv, gs;
    beat_t b;
    ld = (mq.size() == 0) || OUT_READY;
    if (m_lock) begin
      gs = m_lsrc;
      gv = m_lsrc ? IN2_VALID : IN1_VALID;
    end else begin
      gv = IN1_VALID || IN2_VALID;
      gs = (IN1_VALID && IN2_VALID) ? m_pri : IN2_VALID;
    end
    check("m_in1_ready", {31'd0, IN1_READY}, {31'd0, RST_N && ld && gv && !gs});
    check("m_in2_ready", {31'd0, IN2_READY}, {31'd0, RST_N && ld && gv &&  gs});
    check("m_out_valid", {31'd0, OUT_VALID}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("m_out_data", OUT_DATA, mq[0].data);
      check("m_out_last", {31'd0, OUT_LAST}, {31'd0, mq[0].last});
      check("m_out_src",  {31'd0, OUT_SRC},  {31'd0, mq[0].src});
    end
    if (!RST_N) begin
      mq.delete();
      m_pri  = 1'b0;
      m_lock = 1'b0;
    end else begin
      if (mq.size() != 0 && OUT_READY) void'(mq.pop_front());
      if (ld && gv) begin
        b.src  = gs;
        b.last = gs ? IN2_LAST : IN1_LAST;
        b.data = gs ? IN2_DATA : IN1_DATA;
        mq.push_back(b);
`ifdef NET2_ARBITER_PKT_LOCK_EN
        if (b.last) begin
          m_pri  = ~gs;
          m_lock = 1'b0;
        end else begin
          m_lock = 1'b1;
          m_lsrc = gs;
        end
`else
        m_pri = ~gs;
`endif
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_seq;
    logic       acc1;
    int         k;
    RST_N = 1'b0; OUT_READY = 1'b0;
    IN1_DATA = '0; IN1_VALID = 1'b1; IN1_LAST = 1'b0;
    IN2_DATA = '0; IN2_VALID = 1'b0; IN2_LAST = 1'b0;
    #3;
    check("rst_in1_ready", {31'd0, IN1_READY}, 32'd0);
    repeat (2) step();
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_out_data",  OUT_DATA,           32'd0);
    check("rst_out_last",  {31'd0, OUT_LAST},  32'd0);
    check("rst_out_src",   {31'd0, OUT_SRC},   32'd0);

    // Single beat from IN1 right after reset
    RST_N = 1'b1; OUT_READY = 1'b1;
    IN1_DATA = 32'hA5; IN1_VALID = 1'b1; IN1_LAST = 1'b1;
    #3;
    check("a5_in1_ready", {31'd0, IN1_READY}, 32'd1);
    check("a5_in2_ready", {31'd0, IN2_READY}, 32'd0);
    step();
    check("a5_out_valid", {31'd0, OUT_VALID}, 32'd1);
    check("a5_out_data",  OUT_DATA,           32'hA5);
    check("a5_out_src",   {31'd0, OUT_SRC},   32'd0);
    IN1_VALID = 1'b0;
    step();

    // Both requesters streaming single-beat packets
    do_reset();
    OUT_READY = 1'b1;
    IN1_VALID = 1'b1; IN1_LAST = 1'b1;
    IN2_VALID = 1'b1; IN2_LAST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN1_DATA = 32'h100 + i;
      IN2_DATA = 32'h200 + i;
      step();
      check("rr_out_valid", {31'd0, OUT_VALID}, 32'd1);
      check("rr_out_src",   {31'd0, OUT_SRC},   {31'd0, i[0]});
      check("rr_out_data",  OUT_DATA,           i[0] ? 32'h200 + i : 32'h100 + i);
    end

    // Back-pressure for three cycles, then drain and refill together
    OUT_READY = 1'b0; IN1_DATA = 32'h1AA; IN2_DATA = 32'h2BB;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("bp_in1_ready", {31'd0, IN1_READY}, 32'd0);
      check("bp_in2_ready", {31'd0, IN2_READY}, 32'd0);
      step();
      check("bp_out_data",  OUT_DATA,           32'h203);
      check("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
    end
    OUT_READY = 1'b1;
    #3;
    check("refill_in1_ready", {31'd0, IN1_READY}, 32'd1);
    step();
    check("refill_out_data", OUT_DATA,         32'h1AA);
    check("refill_out_src",  {31'd0, OUT_SRC}, 32'd0);
    IN1_VALID = 1'b0; IN2_VALID = 1'b0;
    step();

    // Three-beat packet from IN1 while IN2 keeps requesting
`ifdef NET2_ARBITER_PKT_LOCK_EN
    exp_seq = 4'b1000;
`else
    exp_seq = 4'b1010;
`endif
    do_reset();
    OUT_READY = 1'b1;
    IN2_VALID = 1'b1; IN2_LAST = 1'b1; IN2_DATA = 32'h2C0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      IN1_VALID = (k < 3);
      IN1_DATA  = 32'h300 + k;
      IN1_LAST  = (k == 2);
      #3;
      acc1 = IN1_READY;
      step();
      check("pkt_out_src", {31'd0, OUT_SRC}, {31'd0, exp_seq[c]});
      if (acc1) k++;
    end
    IN1_VALID = 1'b0; IN2_VALID = 1'b0;
    step();

    // Reset while a beat is held and IN2 is mid-packet
    do_reset();
    OUT_READY = 1'b1;
    IN1_VALID = 1'b1; IN1_LAST = 1'b1; IN1_DATA = 32'h410;
    IN2_VALID = 1'b1; IN2_LAST = 1'b1; IN2_DATA = 32'h420;
    step();
    IN1_VALID = 1'b0; IN2_LAST = 1'b0; IN2_DATA = 32'h421;
    step();
    check("mid_out_valid", {31'd0, OUT_VALID}, 32'd1);
    check("mid_out_src",   {31'd0, OUT_SRC},   32'd1);
    IN1_VALID = 1'b1;
    RST_N = 1'b0;
    #3;
    check("mid_rst_in1_ready", {31'd0, IN1_READY}, 32'd0);
    check("mid_rst_in2_ready", {31'd0, IN2_READY}, 32'd0);
    step();
    check("mid_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("mid_rst_out_data",  OUT_DATA,           32'd0);
    RST_N = 1'b1; IN2_LAST = 1'b1;
    #3;
    check("post_rst_in1_ready", {31'd0, IN1_READY}, 32'd1);
    check("post_rst_in2_ready", {31'd0, IN2_READY}, 32'd0);
    step();
    check("post_rst_out_src",  {31'd0, OUT_SRC}, 32'd0);
    check("post_rst_out_data", OUT_DATA,         32'h410);
    IN1_VALID = 1'b0; IN2_VALID = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
